// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI initiator: controller state
// encoding, byte/bit-counter widths and the default timing values.
package spi_pkg;

    localparam int SPI_BYTE_W    = 8;
    localparam int SPI_BIT_CNT_W = 3;
    localparam int SPI_DIV_W     = 8;

    // Default timing, all in sclk cycles
    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_CS_SETUP = 2;
    localparam int DEF_CS_HOLD  = 2;
    localparam int DEF_CS_IDLE  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_NEXT,
        ST_HOLD,
        ST_GAP
    } spi_ctl_state_t;

    // Converts a cycle count into a terminal value for the phase counter
    function automatic logic [SPI_DIV_W-1:0] div_term(input int cycles);
        return SPI_DIV_W'(cycles);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Phase counter shared by every timed state. A load starts a new phase of
// 'term' cycles; phase_done is high in the last cycle of that phase, so the
// controller acts on the edge exactly 'term' cycles after the load. The
// counter stops by itself when a phase ends without a reload.
module spi_clk_div
    import spi_pkg::*;
(
    input  logic                 sclk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [SPI_DIV_W-1:0] term,
    input  logic                 clear,
    output logic                 phase_done
);

    logic [SPI_DIV_W-1:0] cnt_reg;
    logic [SPI_DIV_W-1:0] term_reg;
    logic                 active_reg;

    assign phase_done = active_reg && (cnt_reg == term_reg);

    // Count cycles of the current phase; load wins over clear and expiry
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            term_reg   <= '0;
            active_reg <= 1'b0;
        end else if (load) begin
            cnt_reg    <= SPI_DIV_W'(1);
            term_reg   <= term;
            active_reg <= 1'b1;
        end else if (clear || phase_done) begin
            cnt_reg    <= '0;
            active_reg <= 1'b0;
        end else if (active_reg) begin
            cnt_reg    <= cnt_reg + SPI_DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// Byte-oriented SPI initiator, mode 0, MSB first. Bytes arrive on a
// valid/ready handshake; chip select stays low across a burst until a byte
// marked tx_last has been shifted out. Received bytes are presented with a
// one-cycle rx_valid pulse on the same edge as the final spi_clk fall.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int CS_SETUP = DEF_CS_SETUP,
    parameter int CS_HOLD  = DEF_CS_HOLD,
    parameter int CS_IDLE  = DEF_CS_IDLE
) (
    input  logic                  sclk,
    input  logic                  rst_n,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_last,
    output logic                  rx_valid,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  busy,
    output logic                  spi_clk,
    output logic                  spi_cs_n,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam logic [SPI_DIV_W-1:0] HALF_TERM  = div_term(CLK_DIV);
    localparam logic [SPI_DIV_W-1:0] SETUP_TERM = div_term(CS_SETUP);
    localparam logic [SPI_DIV_W-1:0] HOLD_TERM  = div_term(CS_HOLD);
    localparam logic [SPI_DIV_W-1:0] IDLE_TERM  = div_term(CS_IDLE);
    // After a burst handshake the first rising edge follows on the next cycle
    localparam logic [SPI_DIV_W-1:0] RESUME_TERM = div_term(1);

    spi_ctl_state_t            state_reg;
    logic [SPI_BYTE_W-2:0]     tx_rem_reg;   // bits still to be driven after the current one
    logic [SPI_BYTE_W-1:0]     rx_sr_reg;
    logic [SPI_BIT_CNT_W-1:0]  bit_cnt_reg;  // wraps to 0 after the 8th sample
    logic                      last_reg;
    logic                      spi_clk_reg;
    logic                      spi_cs_n_reg;
    logic                      spi_mosi_reg;
    logic                      rx_valid_reg;
    logic [SPI_BYTE_W-1:0]     rx_data_reg;

    logic                      handshake;
    logic                      byte_done;
    logic                      phase_done;
    logic                      div_load;
    logic                      div_clear;
    logic [SPI_DIV_W-1:0]      div_term_sel;

    assign tx_ready  = (state_reg == ST_IDLE) || (state_reg == ST_NEXT);
    assign busy      = (state_reg != ST_IDLE);
    assign handshake = tx_valid && tx_ready;
    // Every SHIFT_HI follows at least one sample, so a zero count there means eight
    assign byte_done = (bit_cnt_reg == '0);

    assign spi_clk  = spi_clk_reg;
    assign spi_cs_n = spi_cs_n_reg;
    assign spi_mosi = spi_mosi_reg;
    assign rx_valid = rx_valid_reg;
    assign rx_data  = rx_data_reg;

    spi_clk_div u_clk_div (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .load       (div_load),
        .term       (div_term_sel),
        .clear      (div_clear),
        .phase_done (phase_done)
    );

    // Select the length of the phase that starts on this edge, if any
    always_comb begin
        div_load     = 1'b0;
        div_clear    = 1'b0;
        div_term_sel = HALF_TERM;
        case (state_reg)
            ST_IDLE: begin
                if (handshake) begin
                    div_load     = 1'b1;
                    div_term_sel = SETUP_TERM;
                end
            end
            ST_SETUP, ST_SHIFT_LO: begin
                if (phase_done) begin
                    div_load = 1'b1;
                end
            end
            ST_SHIFT_HI: begin
                if (phase_done) begin
                    if (!byte_done) begin
                        div_load = 1'b1;
                    end else if (last_reg) begin
                        div_load     = 1'b1;
                        div_term_sel = HOLD_TERM;
                    end else begin
                        div_clear = 1'b1;
                    end
                end
            end
            ST_NEXT: begin
                if (handshake) begin
                    div_load     = 1'b1;
                    div_term_sel = RESUME_TERM;
                end
            end
            ST_HOLD: begin
                if (phase_done) begin
                    div_load     = 1'b1;
                    div_term_sel = IDLE_TERM;
                end
            end
            ST_GAP: begin
                if (phase_done) begin
                    div_clear = 1'b1;
                end
            end
            default: begin
                div_clear = 1'b1;
            end
        endcase
    end

    // Transfer sequencer: pins, shift registers and received-byte output
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            tx_rem_reg   <= '0;
            rx_sr_reg    <= '0;
            bit_cnt_reg  <= '0;
            last_reg     <= 1'b0;
            spi_clk_reg  <= 1'b0;
            spi_cs_n_reg <= 1'b1;
            spi_mosi_reg <= 1'b0;
            rx_valid_reg <= 1'b0;
            rx_data_reg  <= '0;
        end else begin
            rx_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (handshake) begin
                        tx_rem_reg   <= tx_data[SPI_BYTE_W-2:0];
                        last_reg     <= tx_last;
                        bit_cnt_reg  <= '0;
                        spi_cs_n_reg <= 1'b0;
                        spi_mosi_reg <= tx_data[SPI_BYTE_W-1];
                        state_reg    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (phase_done) begin
                        spi_clk_reg <= 1'b1;
                        rx_sr_reg   <= {rx_sr_reg[SPI_BYTE_W-2:0], spi_miso};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        state_reg   <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (phase_done) begin
                        spi_clk_reg <= 1'b0;
                        if (!byte_done) begin
                            // Next bit goes out on the falling edge, never on a rise
                            spi_mosi_reg <= tx_rem_reg[SPI_BYTE_W-2];
                            tx_rem_reg   <= {tx_rem_reg[SPI_BYTE_W-3:0], 1'b0};
                            state_reg    <= ST_SHIFT_LO;
                        end else begin
                            rx_data_reg  <= rx_sr_reg;
                            rx_valid_reg <= 1'b1;
                            state_reg    <= last_reg ? ST_HOLD : ST_NEXT;
                        end
                    end
                end
                ST_SHIFT_LO: begin
                    if (phase_done) begin
                        spi_clk_reg <= 1'b1;
                        rx_sr_reg   <= {rx_sr_reg[SPI_BYTE_W-2:0], spi_miso};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        state_reg   <= ST_SHIFT_HI;
                    end
                end
                ST_NEXT: begin
                    // Chip select stays asserted; wait as long as needed for the next byte
                    if (handshake) begin
                        tx_rem_reg   <= tx_data[SPI_BYTE_W-2:0];
                        last_reg     <= tx_last;
                        bit_cnt_reg  <= '0;
                        spi_mosi_reg <= tx_data[SPI_BYTE_W-1];
                        state_reg    <= ST_SHIFT_LO;
                    end
                end
                ST_HOLD: begin
                    if (phase_done) begin
                        spi_cs_n_reg <= 1'b1;
                        spi_mosi_reg <= 1'b0;
                        state_reg    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (phase_done) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
